// File: rtl/map_scaler_pipe.sv
`timescale 1ns/1ps
// Raster-to-map address generator: sub-pixel step counters with optional 2x zoom and a
// per-frame latched pan window. Two register stages, vid_addr/addr_valid 2 clk after inputs.
module map_scaler_pipe #(
  parameter int unsigned PIX_BITS   = 12,
  parameter int unsigned MAP_W_BITS = 7,
  parameter int unsigned MAP_H_BITS = 7,
  parameter int unsigned SCALE_X    = 8,
  parameter int unsigned SCALE_Y    = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PIX_BITS-1:0]            pixel_row,
  input  logic [PIX_BITS-1:0]            pixel_column,
  input  logic                           video_on,
  input  logic                           zoom,
  input  logic [MAP_W_BITS-1:0]          pan_x,
  input  logic [MAP_H_BITS-1:0]          pan_y,
  output logic [MAP_W_BITS+MAP_H_BITS-1:0] vid_addr,
  output logic                           addr_valid
);

  localparam int unsigned SUBX_W = $clog2(2 * SCALE_X);
  localparam int unsigned SUBY_W = $clog2(2 * SCALE_Y);
  localparam logic [SUBX_W-1:0] SX_LAST_Z0 = SUBX_W'(SCALE_X - 1);
  localparam logic [SUBX_W-1:0] SX_LAST_Z1 = SUBX_W'(2 * SCALE_X - 1);
  localparam logic [SUBY_W-1:0] SY_LAST_Z0 = SUBY_W'(SCALE_Y - 1);
  localparam logic [SUBY_W-1:0] SY_LAST_Z1 = SUBY_W'(2 * SCALE_Y - 1);

  // Stage 1: registered inputs plus the previous registered coordinates for change detection
  logic [PIX_BITS-1:0]   row_q, col_q, row_prev_q, col_prev_q;
  logic                  von_q, zoom_q;
  logic [MAP_W_BITS-1:0] pan_x_q;
  logic [MAP_H_BITS-1:0] pan_y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q      <= '0;
      col_q      <= '0;
      row_prev_q <= '0;
      col_prev_q <= '0;
      von_q      <= 1'b0;
      zoom_q     <= 1'b0;
      pan_x_q    <= '0;
      pan_y_q    <= '0;
    end else begin
      row_q      <= pixel_row;
      col_q      <= pixel_column;
      row_prev_q <= row_q;
      col_prev_q <= col_q;
      von_q      <= video_on;
      zoom_q     <= zoom;
      pan_x_q    <= pan_x;
      pan_y_q    <= pan_y;
    end
  end

  logic col_step, row_step, line_start, frame_start;

  always_comb begin
    col_step    = von_q && (col_q != col_prev_q);
    row_step    = (row_q != row_prev_q);
    line_start  = (col_q == '0);
    frame_start = line_start && (row_q == '0);
  end

  // Stage 2: step counters, per-frame shadow of zoom/pan, registered outputs
  logic [SUBX_W-1:0]     col_sub_q, col_sub_d;
  logic [SUBY_W-1:0]     row_sub_q, row_sub_d;
  logic [MAP_W_BITS-1:0] col_cnt_q, col_cnt_d;
  logic [MAP_H_BITS-1:0] row_cnt_q, row_cnt_d;
  logic                  zoom_s_q, zoom_s_d;
  logic [MAP_W_BITS-1:0] pan_x_s_q, pan_x_s_d;
  logic [MAP_H_BITS-1:0] pan_y_s_q, pan_y_s_d;
  logic [MAP_W_BITS+MAP_H_BITS-1:0] vid_addr_q, vid_addr_d;
  logic                  valid_q, valid_d;

  logic [SUBX_W-1:0]     sx_last;
  logic [SUBY_W-1:0]     sy_last;
  logic [MAP_W_BITS-1:0] map_col;
  logic [MAP_H_BITS-1:0] map_row;

  always_comb begin
    zoom_s_d   = zoom_s_q;
    pan_x_s_d  = pan_x_s_q;
    pan_y_s_d  = pan_y_s_q;
    col_sub_d  = col_sub_q;
    col_cnt_d  = col_cnt_q;
    row_sub_d  = row_sub_q;
    row_cnt_d  = row_cnt_q;
    sx_last    = zoom_s_q ? SX_LAST_Z1 : SX_LAST_Z0;
    sy_last    = zoom_s_q ? SY_LAST_Z1 : SY_LAST_Z0;

    if (frame_start) begin
      zoom_s_d  = zoom_q;
      pan_x_s_d = pan_x_q;
      pan_y_s_d = pan_y_q;
    end

    if (line_start) begin
      col_sub_d = '0;
      col_cnt_d = '0;
    end else if (col_step) begin
      if (col_sub_q == sx_last) begin
        col_sub_d = '0;
        col_cnt_d = col_cnt_q + MAP_W_BITS'(1);
      end else begin
        col_sub_d = col_sub_q + SUBX_W'(1);
      end
    end

    if (frame_start) begin
      row_sub_d = '0;
      row_cnt_d = '0;
    end else if (row_step) begin
      if (row_sub_q == sy_last) begin
        row_sub_d = '0;
        row_cnt_d = row_cnt_q + MAP_H_BITS'(1);
      end else begin
        row_sub_d = row_sub_q + SUBY_W'(1);
      end
    end

    // Uses the shadow values being loaded this cycle so the frame-start pixel already sees the new window
    map_col    = (zoom_s_d ? pan_x_s_d : '0) + col_cnt_d;
    map_row    = (zoom_s_d ? pan_y_s_d : '0) + row_cnt_d;
    valid_d    = von_q;
    vid_addr_d = von_q ? {map_row, map_col} : vid_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_sub_q  <= '0;
      col_cnt_q  <= '0;
      row_sub_q  <= '0;
      row_cnt_q  <= '0;
      zoom_s_q   <= 1'b0;
      pan_x_s_q  <= '0;
      pan_y_s_q  <= '0;
      vid_addr_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      col_sub_q  <= col_sub_d;
      col_cnt_q  <= col_cnt_d;
      row_sub_q  <= row_sub_d;
      row_cnt_q  <= row_cnt_d;
      zoom_s_q   <= zoom_s_d;
      pan_x_s_q  <= pan_x_s_d;
      pan_y_s_q  <= pan_y_s_d;
      vid_addr_q <= vid_addr_d;
      valid_q    <= valid_d;
    end
  end

  assign vid_addr   = vid_addr_q;
  assign addr_valid = valid_q;

endmodule

// File: tb/tb_map_scaler_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for map_scaler_pipe: the driver queues hand-computed expectations per pixel,
// the monitor pops and compares them 2 clk later, and probes the outputs while reset is held.
module tb_map_scaler_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] row_i = '0;
  logic [11:0] col_i = '0;
  logic        von = 1'b0;
  logic        zoom = 1'b0;
  logic [6:0]  px = '0;
  logic [6:0]  py = '0;
  logic [13:0] vid_addr;
  logic        addr_valid;

  typedef struct {
    int tag;
    int r;
    int c;
    bit chk;
    bit v;
    int a;
  } exp_t;

  exp_t sb[$];
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  map_scaler_pipe #(
    .PIX_BITS  (12),
    .MAP_W_BITS(7),
    .MAP_H_BITS(7),
    .SCALE_X   (8),
    .SCALE_Y   (6)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .pixel_row   (row_i),
    .pixel_column(col_i),
    .video_on    (von),
    .zoom        (zoom),
    .pan_x       (px),
    .pan_y       (py),
    .vid_addr    (vid_addr),
    .addr_valid  (addr_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic put(input int r, input int c, input bit v, input bit chk, input int a);
    row_i = 12'(r);
    col_i = 12'(c);
    von   = v;
    sb.push_back('{tag: edge_n, r: r, c: c, chk: chk, v: v, a: a});
  endtask

  task automatic pix(input int r, input int c, input bit v, input bit chk, input int a);
    @(negedge clk);
    put(r, c, v, chk, a);
  endtask

  task automatic pix4(input int r, input int c, input bit v, input bit chk, input int a);
    repeat (4) pix(r, c, v, chk, a);
  endtask

  // Monitor: sole owner of the counters
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (done) begin
        n_checks++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
      if (rst) begin
        n_checks++;
        if (vid_addr != '0 || addr_valid != 1'b0) begin
          n_fail++;
          $display("FAIL reset_state: got addr %0d valid %0b, want addr 0 valid 0",
                   vid_addr, addr_valid);
        end
        sb.delete();
      end else begin
        while (sb.size() > 0 && sb[0].tag + 2 <= edge_n) begin
          e = sb.pop_front();
          n_checks++;
          if (e.tag + 2 != edge_n) begin
            n_fail++;
            $display("FAIL late(%0d,%0d): compared at edge %0d, want edge %0d",
                     e.r, e.c, edge_n, e.tag + 2);
          end else if (addr_valid != e.v) begin
            n_fail++;
            $display("FAIL valid(%0d,%0d): got %0b, want %0b", e.r, e.c, addr_valid, e.v);
          end else if (e.chk && int'(vid_addr) != e.a) begin
            n_fail++;
            $display("FAIL addr(%0d,%0d): got %0d, want %0d", e.r, e.c, vid_addr, e.a);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Zoom 0, one pixel per clk; rows are advanced on column 0 only
    pix(0, 0, 1, 1, 0);
    for (int c = 1; c <= 1023; c++)
      pix(0, c, 1, c == 7 || c == 8 || c == 1023, c == 7 ? 0 : (c == 8 ? 1 : 127));
    for (int c = 1024; c <= 1031; c++) pix(0, c, 0, 1, 127);
    for (int r = 1; r <= 6; r++) pix(r, 0, 1, r >= 5, r == 6 ? 128 : 0);
    for (int c = 1; c <= 8; c++) pix(6, c, 1, c == 8, 129);
    for (int r = 7; r <= 767; r++) pix(r, 0, 1, r == 767, 16256);
    for (int c = 1; c <= 1023; c++) pix(767, c, 1, c == 1023, 16383);

    // Zoom 1, pan 0
    zoom = 1'b1; px = 7'd0; py = 7'd0;
    pix(0, 0, 1, 1, 0);
    for (int c = 1; c <= 16; c++) pix(0, c, 1, c >= 15, c == 16 ? 1 : 0);
    for (int r = 1; r <= 12; r++) pix(r, 0, 1, r >= 11, r == 12 ? 128 : 0);
    for (int r = 13; r <= 767; r++) pix(r, 0, 1, r == 767, 8064);
    for (int c = 1; c <= 1023; c++) pix(767, c, 1, c == 1023, 8127);

    // Pan wrap-around
    px = 7'd120; py = 7'd125;
    pix(0, 0, 1, 1, 16120);
    for (int c = 1; c <= 160; c++) pix(0, c, 1, c == 160, 16002);
    for (int r = 1; r <= 60; r++) pix(r, 0, 1, r >= 59, r == 60 ? 376 : 248);
    for (int c = 1; c <= 160; c++) pix(60, c, 1, c >= 159, c == 160 ? 258 : 257);

    // Mid-frame zoom/pan change takes effect only at the next frame start
    zoom = 1'b0;
    pix(0, 0, 1, 1, 0);
    for (int r = 1; r <= 299; r++) pix(r, 0, 1, r == 299, 6272);
    zoom = 1'b1; px = 7'd3; py = 7'd4;
    pix(300, 0, 1, 1, 6400);
    for (int c = 1; c <= 8; c++) pix(300, c, 1, c == 8, 6401);
    for (int r = 301; r <= 767; r++) pix(r, 0, 1, r == 767, 16256);
    pix(0, 0, 1, 1, 515);
    for (int c = 1; c <= 16; c++) pix(0, c, 1, c >= 15, c == 16 ? 516 : 515);

    // Quarter-rate pixel enable with blanking
    zoom = 1'b0; px = 7'd0; py = 7'd0;
    pix4(0, 0, 1, 1, 0);
    for (int c = 1; c <= 1023; c++)
      pix4(0, c, 1, c == 7 || c == 8 || c == 1023, c == 7 ? 0 : (c == 8 ? 1 : 127));
    for (int c = 1024; c <= 1039; c++) pix4(0, c, 0, 1, 127);
    for (int r = 1; r <= 6; r++) pix4(r, 0, 1, 1, r == 6 ? 128 : 0);
    for (int c = 1; c <= 8; c++) pix4(6, c, 1, c >= 7, c == 8 ? 129 : 128);
    for (int c = 1024; c <= 1027; c++) pix4(6, c, 0, 1, 129);
    pix(7, 0, 1, 1, 128);

    // Asynchronous reset mid-cycle, then unsynchronised run until line/frame start
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    put(300, 500, 1, 1, 0);
    for (int c = 501; c <= 507; c++) pix(300, c, 1, c >= 506, c == 507 ? 1 : 0);
    for (int r = 301; r <= 305; r++) pix(r, 0, 1, r >= 304, r == 305 ? 128 : 0);
    pix(0, 0, 1, 1, 0);
    for (int c = 1; c <= 8; c++) pix(0, c, 1, c >= 7, c == 8 ? 1 : 0);

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
